// File: rtl/branch_redirect_ctrl_pkg.sv
// rtl/branch_redirect_ctrl_pkg.sv - shared widths and FSM encoding for the branch redirect controller
package branch_redirect_ctrl_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_CNT_W  = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } redir_state_e;

endpackage

// File: rtl/branch_redirect_ctrl_perf_counter.sv
// rtl/branch_redirect_ctrl_perf_counter.sv - wrapping event counter with enable
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - redirect sequencing, delay-slot tracking and branch counters
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int CNT_W  = BUS_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_fire,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_addr,
    input  logic              next_inst_delayslot_flag,
    input  logic              exc_flush,
    input  logic [ADDR_W-1:0] exc_pc,
    input  logic              pc_ready,
    output logic              pc_redirect,
    output logic [ADDR_W-1:0] pc_target,
    output logic              if_flush,
    output logic              id_in_delayslot,
    output logic              id_hold,
    output logic              ds_branch_err,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  taken_cnt
);

    redir_state_e      state;
    redir_state_e      state_nxt;
    logic [ADDR_W-1:0] target;
    logic              ds_pending;
    logic              ds_consumed;
    logic              exc_flush_q;
    logic              ds_err_q;

    logic branch_go;
    logic branch_accept;
    logic taken_accept;
    logic nested_branch;

    // A branch sitting in a delay slot is never acted on; only the outer branch counts.
    assign branch_go     = id_fire & branch_flag & ~ds_pending;
    assign branch_accept = id_fire & next_inst_delayslot_flag & ~ds_pending & ~exc_flush;
    assign taken_accept  = branch_accept & branch_flag;
    assign nested_branch = id_fire & next_inst_delayslot_flag & ds_pending & ~exc_flush;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (exc_flush || branch_go) begin
                    state_nxt = ST_PEND;
                end
            end
            ST_PEND: begin
                if (exc_flush) begin
                    state_nxt = ST_PEND;
                end else if (pc_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            target      <= '0;
            ds_pending  <= 1'b0;
            ds_consumed <= 1'b0;
            exc_flush_q <= 1'b0;
            ds_err_q    <= 1'b0;
        end else begin
            exc_flush_q <= exc_flush;
            ds_err_q    <= nested_branch;
            if (exc_flush) begin
                target      <= exc_pc;
                ds_pending  <= 1'b0;
                ds_consumed <= 1'b0;
            end else begin
                if (state == ST_IDLE && branch_go) begin
                    target <= branch_addr;
                end
                // Any ID departure closes the slot; a new slot opens only for an outer branch.
                if (id_fire) begin
                    ds_pending <= next_inst_delayslot_flag & ~ds_pending;
                end
                if (state == ST_PEND) begin
                    if (pc_ready) begin
                        ds_consumed <= 1'b0;
                    end else if (id_fire && ds_pending) begin
                        ds_consumed <= 1'b1;
                    end
                end
            end
        end
    end

    assign pc_redirect     = (state == ST_PEND);
    assign pc_target       = target;
    assign id_in_delayslot = ds_pending;
    assign id_hold         = (state == ST_PEND) & ds_consumed;
    assign ds_branch_err   = ds_err_q;
    // Late acceptance means IF already holds a sequential fetch past the delay slot.
    assign if_flush        = (pc_redirect & pc_ready & ds_consumed) | exc_flush_q;

    perf_counter #(.CNT_W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .rst_n (rst),
        .en    (branch_accept),
        .count (branch_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .rst_n (rst),
        .en    (taken_accept),
        .count (taken_cnt)
    );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - directed self-checking bench for branch_redirect_ctrl
module tb_branch_redirect_ctrl;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              id_fire = 1'b0;
    logic              branch_flag = 1'b0;
    logic [ADDR_W-1:0] branch_addr = '0;
    logic              next_inst_delayslot_flag = 1'b0;
    logic              exc_flush = 1'b0;
    logic [ADDR_W-1:0] exc_pc = '0;
    logic              pc_ready = 1'b0;
    logic              pc_redirect;
    logic [ADDR_W-1:0] pc_target;
    logic              if_flush;
    logic              id_in_delayslot;
    logic              id_hold;
    logic              ds_branch_err;
    logic [CNT_W-1:0]  branch_cnt;
    logic [CNT_W-1:0]  taken_cnt;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .id_fire                  (id_fire),
        .branch_flag              (branch_flag),
        .branch_addr              (branch_addr),
        .next_inst_delayslot_flag (next_inst_delayslot_flag),
        .exc_flush                (exc_flush),
        .exc_pc                   (exc_pc),
        .pc_ready                 (pc_ready),
        .pc_redirect              (pc_redirect),
        .pc_target                (pc_target),
        .if_flush                 (if_flush),
        .id_in_delayslot          (id_in_delayslot),
        .id_hold                  (id_hold),
        .ds_branch_err            (ds_branch_err),
        .branch_cnt               (branch_cnt),
        .taken_cnt                (taken_cnt)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        id_fire = 1'b0; branch_flag = 1'b0; next_inst_delayslot_flag = 1'b0;
        exc_flush = 1'b0; pc_ready = 1'b0;
    endtask

    task automatic fire(input logic is_br, input logic taken, input logic [ADDR_W-1:0] addr);
        id_fire = 1'b1; next_inst_delayslot_flag = is_br; branch_flag = taken; branch_addr = addr;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        quiet_inputs();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        pc_ready = 1'b0;
        fire(1'b1, 1'b1, 32'h0000_0040);
        tick();
        quiet_inputs();
        #1;
        checks++; if (pc_redirect !== 1'b1) begin fails++; $display("FAIL reset_pre_redirect: got %b expected 1", pc_redirect); end
        rst = 1'b0;
        #1;
        checks++; if (pc_redirect !== 1'b0) begin fails++; $display("FAIL reset_async_redirect: got %b expected 0", pc_redirect); end
        checks++; if (pc_target !== 32'h0) begin fails++; $display("FAIL reset_target: got %h expected 0", pc_target); end
        checks++; if (id_in_delayslot !== 1'b0) begin fails++; $display("FAIL reset_ds: got %b expected 0", id_in_delayslot); end
        checks++; if (branch_cnt !== 4'd0 || taken_cnt !== 4'd0) begin fails++; $display("FAIL reset_cnts: got %0d/%0d expected 0/0", branch_cnt, taken_cnt); end
        tick();
        rst = 1'b1;
        tick();
        checks++; if (pc_redirect !== 1'b0 || id_hold !== 1'b0 || if_flush !== 1'b0 || ds_branch_err !== 1'b0) begin
            fails++; $display("FAIL reset_release_idle: redirect=%b hold=%b flush=%b err=%b expected all 0", pc_redirect, id_hold, if_flush, ds_branch_err); end
    endtask

    task automatic test_taken_branch();
        apply_reset();
        pc_ready = 1'b1;
        fire(1'b1, 1'b1, 32'h0000_0100);
        tick();
        id_fire = 1'b0; branch_flag = 1'b0; next_inst_delayslot_flag = 1'b0;
        #1;
        checks++; if (pc_redirect !== 1'b1 || pc_target !== 32'h100) begin fails++; $display("FAIL taken_redirect: got %b/%h expected 1/00000100", pc_redirect, pc_target); end
        checks++; if (id_in_delayslot !== 1'b1) begin fails++; $display("FAIL taken_ds_t1: got %b expected 1", id_in_delayslot); end
        checks++; if (branch_cnt !== 4'd1 || taken_cnt !== 4'd1) begin fails++; $display("FAIL taken_cnts: got %0d/%0d expected 1/1", branch_cnt, taken_cnt); end
        tick();
        checks++; if (pc_redirect !== 1'b0) begin fails++; $display("FAIL taken_redirect_drop: got %b expected 0", pc_redirect); end
        checks++; if (id_in_delayslot !== 1'b1) begin fails++; $display("FAIL taken_ds_hold: got %b expected 1", id_in_delayslot); end
        fire(1'b0, 1'b0, 32'h0);
        tick();
        id_fire = 1'b0;
        #1;
        checks++; if (id_in_delayslot !== 1'b0) begin fails++; $display("FAIL taken_ds_clear: got %b expected 0", id_in_delayslot); end
        checks++; if (pc_target !== 32'h100) begin fails++; $display("FAIL taken_target_hold: got %h expected 00000100", pc_target); end
    endtask

    task automatic test_not_taken();
        apply_reset();
        pc_ready = 1'b1;
        fire(1'b1, 1'b0, 32'h0000_0999);
        tick();
        id_fire = 1'b0;
        #1;
        checks++; if (pc_redirect !== 1'b0) begin fails++; $display("FAIL nt_redirect: got %b expected 0", pc_redirect); end
        checks++; if (id_in_delayslot !== 1'b1) begin fails++; $display("FAIL nt_ds: got %b expected 1", id_in_delayslot); end
        checks++; if (branch_cnt !== 4'd1 || taken_cnt !== 4'd0) begin fails++; $display("FAIL nt_cnts: got %0d/%0d expected 1/0", branch_cnt, taken_cnt); end
        tick();
        checks++; if (pc_redirect !== 1'b0 || pc_target !== 32'h0) begin fails++; $display("FAIL nt_no_redirect: got %b/%h expected 0/00000000", pc_redirect, pc_target); end
    endtask

    task automatic test_late_redirect();
        apply_reset();
        pc_ready = 1'b0;
        fire(1'b1, 1'b1, 32'h0000_0200);
        tick();
        fire(1'b0, 1'b0, 32'h0);
        #1;
        checks++; if (pc_redirect !== 1'b1 || id_hold !== 1'b0) begin fails++; $display("FAIL late_t1: redirect=%b hold=%b expected 1/0", pc_redirect, id_hold); end
        tick();
        id_fire = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (id_hold !== 1'b1 || if_flush !== 1'b0) begin fails++; $display("FAIL late_hold_%0d: hold=%b flush=%b expected 1/0", i, id_hold, if_flush); end
            tick();
        end
        pc_ready = 1'b1;
        #1;
        checks++; if (if_flush !== 1'b1 || pc_target !== 32'h200 || pc_redirect !== 1'b1) begin
            fails++; $display("FAIL late_accept: flush=%b target=%h redirect=%b expected 1/00000200/1", if_flush, pc_target, pc_redirect); end
        tick();
        pc_ready = 1'b0;
        #1;
        checks++; if (pc_redirect !== 1'b0 || id_hold !== 1'b0 || if_flush !== 1'b0) begin
            fails++; $display("FAIL late_done: redirect=%b hold=%b flush=%b expected 0/0/0", pc_redirect, id_hold, if_flush); end
    endtask

    task automatic test_exception();
        apply_reset();
        pc_ready = 1'b0;
        fire(1'b1, 1'b1, 32'h0000_0300);
        tick();
        id_fire = 1'b0; branch_flag = 1'b0; next_inst_delayslot_flag = 1'b0;
        exc_flush = 1'b1; exc_pc = 32'hBFC0_0380;
        #1;
        checks++; if (pc_target !== 32'h300) begin fails++; $display("FAIL exc_pre_target: got %h expected 00000300", pc_target); end
        tick();
        exc_flush = 1'b0;
        #1;
        checks++; if (pc_target !== 32'hBFC0_0380 || pc_redirect !== 1'b1) begin fails++; $display("FAIL exc_target: got %h/%b expected bfc00380/1", pc_target, pc_redirect); end
        checks++; if (id_in_delayslot !== 1'b0 || if_flush !== 1'b1) begin fails++; $display("FAIL exc_ds_flush: ds=%b flush=%b expected 0/1", id_in_delayslot, if_flush); end
        pc_ready = 1'b1;
        tick();
        pc_ready = 1'b0;
        #1;
        checks++; if (pc_redirect !== 1'b0 || pc_target !== 32'hBFC0_0380) begin fails++; $display("FAIL exc_accept: got %b/%h expected 0/bfc00380", pc_redirect, pc_target); end
        fire(1'b1, 1'b1, 32'h0000_0400);
        exc_flush = 1'b1; exc_pc = 32'h8000_0180;
        tick();
        quiet_inputs();
        #1;
        checks++; if (pc_target !== 32'h8000_0180 || branch_cnt !== 4'd1 || taken_cnt !== 4'd1 || id_in_delayslot !== 1'b0) begin
            fails++; $display("FAIL exc_vs_branch: target=%h cnt=%0d/%0d ds=%b expected 80000180 1/1 0", pc_target, branch_cnt, taken_cnt, id_in_delayslot); end
        pc_ready = 1'b1; exc_flush = 1'b1; exc_pc = 32'h8000_0200;
        tick();
        exc_flush = 1'b0; pc_ready = 1'b0;
        #1;
        checks++; if (pc_redirect !== 1'b1 || pc_target !== 32'h8000_0200) begin fails++; $display("FAIL exc_vs_ready: got %b/%h expected 1/80000200", pc_redirect, pc_target); end
    endtask

    task automatic test_nested_branch();
        apply_reset();
        pc_ready = 1'b1;
        fire(1'b1, 1'b1, 32'h0000_0500);
        tick();
        fire(1'b1, 1'b1, 32'h0000_0600);
        #1;
        checks++; if (pc_redirect !== 1'b1 || pc_target !== 32'h500 || if_flush !== 1'b0) begin
            fails++; $display("FAIL nest_t1: redirect=%b target=%h flush=%b expected 1/00000500/0", pc_redirect, pc_target, if_flush); end
        tick();
        quiet_inputs();
        #1;
        checks++; if (ds_branch_err !== 1'b1) begin fails++; $display("FAIL nest_err_pulse: got %b expected 1", ds_branch_err); end
        checks++; if (pc_redirect !== 1'b0 || pc_target !== 32'h500) begin fails++; $display("FAIL nest_no_redirect: got %b/%h expected 0/00000500", pc_redirect, pc_target); end
        checks++; if (branch_cnt !== 4'd1 || taken_cnt !== 4'd1 || id_in_delayslot !== 1'b0) begin
            fails++; $display("FAIL nest_cnts_ds: cnt=%0d/%0d ds=%b expected 1/1 0", branch_cnt, taken_cnt, id_in_delayslot); end
        tick();
        checks++; if (ds_branch_err !== 1'b0 || pc_redirect !== 1'b0) begin fails++; $display("FAIL nest_err_once: err=%b redirect=%b expected 0/0", ds_branch_err, pc_redirect); end
    endtask

    task automatic test_counter_wrap();
        apply_reset();
        pc_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            fire(1'b1, 1'b0, 32'h0);
            tick();
            fire(1'b0, 1'b0, 32'h0);
            tick();
        end
        quiet_inputs();
        #1;
        checks++; if (branch_cnt !== 4'd1 || taken_cnt !== 4'd0) begin fails++; $display("FAIL wrap_cnts: got %0d/%0d expected 1/0", branch_cnt, taken_cnt); end
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_taken_branch();
        test_not_taken();
        test_late_redirect();
        test_exception();
        test_nested_branch();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Sequencing controller between the ID-stage branch generator and the PC/IF stage. It registers resolved branch targets and exception vectors, and holds each redirect until the PC unit accepts it. It also tracks the MIPS delay slot, so the instruction after a branch is tagged in-delay-slot, and it stalls or flushes younger fetches when the redirect arrives late. It also keeps branch and taken-branch performance counters.

Parameters:
ADDR_W, 32, width of PC and target addresses
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  system clock, all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
id_fire  in  1  the ID instruction leaves ID this cycle (valid and not stalled)
branch_flag  in  1  from the branch generator: branch taken
branch_addr  in  ADDR_W  from the branch generator: taken target
next_inst_delayslot_flag  in  1  from the branch generator: the ID instruction is a branch or jump
exc_flush  in  1  exception or ERET flush request
exc_pc  in  ADDR_W  exception or return vector
pc_ready  in  1  the PC unit accepts a redirect this cycle
pc_redirect  out  1  redirect request to the PC unit
pc_target  out  ADDR_W  redirect address, valid while pc_redirect=1
if_flush  out  1  discard the instruction held in IF
id_in_delayslot  out  1  the instruction now in ID is a delay-slot instruction
id_hold  out  1  stall request to ID
ds_branch_err  out  1  one-cycle pulse: a branch was found in a delay slot
branch_cnt  out  CNT_W  branches and jumps retired from ID
taken_cnt  out  CNT_W  taken branches and jumps retired from ID

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; every output and internal register is 0, including pc_target and both counters.
- State machine, IDLE:
  - exc_flush=1 -> PEND, target=exc_pc, ds_pending=0, ds_consumed=0.
  - Otherwise id_fire & branch_flag & !id_in_delayslot -> PEND, target=branch_addr.
- State machine, PEND:
  - pc_redirect=1 and pc_target=target, both driven from registers.
  - Latency: PEND is entered at edge t, so pc_redirect is first seen high in cycle t+1.
  - pc_ready=1 at an edge -> IDLE, with ds_consumed cleared.
  - pc_redirect stays high and pc_target stays stable until pc_ready is sampled high.
- exc_flush has priority in every state. It reloads target=exc_pc, clears ds_pending and ds_consumed, and aborts any pending branch. If exc_flush arrives in the same cycle as pc_ready in PEND, the FSM stays in PEND with the exception vector.
- exc_flush in the same cycle as an id_fire branch: the exception wins, the branch is dropped, and neither counter changes.
- Delay-slot tracking (register ds_pending):
  - Set when id_fire & next_inst_delayslot_flag & !id_in_delayslot, whether or not the branch is taken.
  - Cleared on the next id_fire or on exc_flush.
  - id_in_delayslot = ds_pending.
- ds_consumed:
  - Set when id_fire & ds_pending while in PEND, meaning the delay slot has left ID before the redirect was accepted.
- id_hold:
  - id_hold = (state==PEND) & ds_consumed.
  - This stops sequential instructions beyond the delay slot from issuing.
- if_flush:
  - if_flush = pc_redirect & pc_ready & ds_consumed.
  - Otherwise if_flush = exc_flush, registered one cycle and paired with the exception redirect.
- Nested branch: id_fire & next_inst_delayslot_flag & id_in_delayslot causes the following.
  - The branch is ignored and no redirect is issued.
  - ds_branch_err pulses high in the next cycle.
  - The counters are not incremented.
  - ds_pending clears normally.
- Counters:
  - branch_cnt += 1 per accepted branch; taken_cnt += 1 when the accepted branch also has branch_flag=1.
  - Both wrap modulo 2^CNT_W.
  - Both hold during exc_flush cycles.
- If id_fire=0, branch inputs are ignored.
- pc_target holds its last value once in IDLE.

Decomposition:
- Shared package or header holds:
  - the state encoding (IDLE=1'b0, PEND=1'b1);
  - ADDR_W and CNT_W defaults, taken from the existing bus-width defines.
- One natural sub-module: perf_counter, a CNT_W wrapping counter with enable, instantiated twice.

Test Plan:
1. Reset mid-PEND: assert rst=0 while pc_redirect=1 -> all outputs 0 immediately; after release, state=IDLE and both counters=0.
2. Taken branch with pc_ready tied high: id_fire=1, next_inst_delayslot_flag=1, branch_flag=1, branch_addr=0x0000_0100 at cycle t ->
   - pc_redirect=1 with pc_target=0x100 in cycle t+1, low at t+2;
   - id_in_delayslot=1 in t+1 until the next id_fire;
   - branch_cnt=1, taken_cnt=1.
3. Not-taken branch: next_inst_delayslot_flag=1, branch_flag=0 -> pc_redirect never rises, id_in_delayslot=1 for the next instruction, branch_cnt=1, taken_cnt=0.
4. Late redirect: pc_ready=0 for 4 cycles after a taken branch to 0x200 while the delay slot fires ->
   - id_hold=1 from the edge after the delay slot fires until acceptance;
   - on the pc_ready=1 cycle, if_flush=1 and pc_target=0x200.
5. Exception override: taken branch to 0x300 pending, then exc_flush=1 with exc_pc=0xBFC0_0380 -> next cycle pc_target=0xBFC0_0380, id_in_delayslot=0, the 0x300 target is never presented again.
6. Branch in delay slot and counter wrap:
   - Second branch fires with id_in_delayslot=1 -> no new redirect, ds_branch_err=1 for exactly one cycle.
   - With CNT_W=4, 17 branches -> branch_cnt=1.
